// File: rtl/hazard_controller.sv
// Pipeline hazard controller: tracks EX/MEM producers and chooses one
// pipeline action per cycle: FREEZE, STALL, FLUSH or RUN.
module hazard_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_is_branch,
  input  logic        branch_sel,
  input  logic        jump_sel,
  input  logic        mem_wait,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        mux_ctrl_signal_sel,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ACT_RUN    = 2'd0,
    ACT_STALL  = 2'd1,
    ACT_FLUSH  = 2'd2,
    ACT_FREEZE = 2'd3
  } action_e;

  logic             r_ex_valid, r_ex_load, r_mem_valid;
  logic [REG_W-1:0] r_ex_dest, r_mem_dest;
  action_e          r_state, w_next;
  logic [CNT_W-1:0] r_stall_cycles, r_flush_count;
  logic             w_load_use, w_branch_haz, w_hazard;
  logic             w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem;

  function automatic logic f_match(input logic v, input logic [REG_W-1:0] d,
                                   input logic [REG_W-1:0] r);
    return v && (d == r) && (r != '0);
  endfunction

  // Source-versus-producer comparisons; register 0 never matches
  assign w_rs_ex  = id_uses_rs && f_match(r_ex_valid,  r_ex_dest,  id_rs);
  assign w_rt_ex  = id_uses_rt && f_match(r_ex_valid,  r_ex_dest,  id_rt);
  assign w_rs_mem = id_uses_rs && f_match(r_mem_valid, r_mem_dest, id_rs);
  assign w_rt_mem = id_uses_rt && f_match(r_mem_valid, r_mem_dest, id_rt);

  assign w_load_use   = r_ex_load && (w_rs_ex || w_rt_ex);
  assign w_branch_haz = id_is_branch && (w_rs_ex || w_rt_ex || w_rs_mem || w_rt_mem);
  assign w_hazard     = w_load_use || w_branch_haz;

  // State register: records the action applied at each edge
  always_ff @(posedge clock) begin
    if (reset) r_state <= ACT_RUN;
    else       r_state <= w_next;
  end

  // Next-state: action priority freeze > stall > flush > run
  always_comb begin
    w_next = ACT_RUN;
    if (mem_wait)                     w_next = ACT_FREEZE;
    else if (w_hazard)                w_next = ACT_STALL;
    else if (branch_sel || jump_sel)  w_next = ACT_FLUSH;
  end

  // Output decode of the action being applied this cycle
  always_comb begin
    pc_write            = 1'b1;
    if_id_write         = 1'b1;
    if_id_flush         = 1'b0;
    mux_ctrl_signal_sel = 1'b1;
    if (reset) begin
      pc_write            = 1'b0;
      if_id_write         = 1'b0;
      if_id_flush         = 1'b1;
      mux_ctrl_signal_sel = 1'b0;
    end else begin
      case (w_next)
        ACT_STALL: begin
          pc_write            = 1'b0;
          if_id_write         = 1'b0;
          mux_ctrl_signal_sel = 1'b0;
        end
        ACT_FLUSH:  if_id_flush = 1'b1;
        ACT_FREEZE: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Producer scoreboard; a stall pushes a bubble into EX, a freeze holds all
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ex_valid  <= 1'b0;
      r_ex_dest   <= '0;
      r_ex_load   <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_dest  <= '0;
    end else if (w_next != ACT_FREEZE) begin
      r_mem_valid <= r_ex_valid;
      r_mem_dest  <= r_ex_dest;
      if (w_next == ACT_STALL) begin
        r_ex_valid <= 1'b0;
        r_ex_dest  <= '0;
        r_ex_load  <= 1'b0;
      end else begin
        r_ex_valid <= id_reg_write && (id_rd != '0);
        r_ex_dest  <= id_rd;
        r_ex_load  <= id_mem_read;
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_next == ACT_STALL && r_stall_cycles != CNT_MAX)
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_next == ACT_FLUSH && r_flush_count != CNT_MAX)
        r_flush_count <= r_flush_count + CNT_W'(1);
    end
  end

  assign state        = r_state;
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have ports: clock  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high.
REQ-003 SHALL have: id_rs, id_rt  in  5 each  source register fields (instruc[25:21], instruc[20:16]) of the instruction in ID.
REQ-004 SHALL have: id_uses_rs, id_uses_rt  in  1 each  ID instruction reads that source.
REQ-005 SHALL have: id_rd  in  5  destination of the ID instruction; id_reg_write  in  1  it writes a register; id_mem_read  in  1  it is a load.
REQ-006 SHALL have: id_is_branch  in  1  branch compared in ID; branch_sel  in  1  branch taken; jump_sel  in  1  jump in ID.
REQ-007 SHALL have: mem_wait  in  1  data memory not ready, freezes the whole pipeline.
REQ-008 SHALL have outputs: pc_write  1  PC load enable; if_id_write  1  IF/ID load enable; if_id_flush  1  load NOP into IF/ID.
REQ-009 SHALL have: mux_ctrl_signal_sel  out  1  1 = pass ID controls, 0 = insert bubble (all-zero controls).
REQ-010 SHALL have: state  out  2  registered action of the last edge: 0 RUN, 1 STALL, 2 FLUSH, 3 FREEZE.
REQ-011 SHALL have: stall_cycles, flush_count  out  16 each  saturating performance counters.

Function
REQ-012 SHALL keep a 2-entry scoreboard (EX, MEM); entry = {valid, dest[4:0], load}; valid only if the producer writes a register and dest != 0.
REQ-013 match(e,r) SHALL be e.valid && e.dest==r && r!=0; register 0 never causes a hazard.
REQ-014 load_use SHALL be EX.load && ((id_uses_rs && match(EX,id_rs)) || (id_uses_rt && match(EX,id_rt))).
REQ-015 branch_haz SHALL be id_is_branch && any used source matching EX or MEM, with no forwarding into ID.
REQ-016 hazard SHALL be load_use || branch_haz; evaluated combinationally in the same cycle.
REQ-017 Action priority SHALL be FREEZE (mem_wait) > STALL (hazard) > FLUSH (branch_sel || jump_sel) > RUN.
REQ-018 RUN SHALL drive pc_write=1, if_id_write=1, if_id_flush=0, mux_ctrl_signal_sel=1.
REQ-019 STALL SHALL drive pc_write=0, if_id_write=0, if_id_flush=0, mux_ctrl_signal_sel=0.
REQ-020 FLUSH SHALL drive pc_write=1, if_id_write=1, if_id_flush=1, mux_ctrl_signal_sel=1; a branch_sel qualified by a hazard is ignored until the hazard clears.
REQ-021 FREEZE SHALL drive pc_write=0, if_id_write=0, if_id_flush=0, mux_ctrl_signal_sel=1.
REQ-022 On each non-FREEZE edge: MEM <= EX; EX <= STALL ? invalid : {id_reg_write && id_rd!=0, id_rd, id_mem_read}.
REQ-023 On a FREEZE edge the scoreboard SHALL hold.
REQ-024 state SHALL register the action applied at each edge.
REQ-025 stall_cycles SHALL increment on each STALL edge; flush_count on each FLUSH edge; both hold at 16'hFFFF.
REQ-026 Hazard latency: load-use SHALL stall exactly 1 cycle; branch after ALU producer 2 cycles; branch after load 2 cycles (EX then MEM match).

Reset
REQ-027 While reset=1, outputs SHALL be pc_write=0, if_id_write=0, if_id_flush=1, mux_ctrl_signal_sel=0.
REQ-028 At a reset edge, the scoreboard SHALL be invalidated, state SHALL be RUN, and counters SHALL clear, overriding any in-flight stall, flush or freeze.
REQ-029 The first cycle after reset deasserts SHALL behave as RUN with an empty scoreboard.

Verification
REQ-030 Load-use: lw r5 in ID, then add r6,r5,r1 -> 1 cycle with pc_write=0, mux_ctrl_signal_sel=0, state=STALL, stall_cycles=1, then RUN.
REQ-031 Branch after ALU: add r3 in ID, then beq r3,r4 -> 2 stall cycles, then FLUSH if branch_sel=1; flush_count=1.
REQ-032 r0 producer: id_rd=0, id_reg_write=1, next instruction reads r0 -> no stall; stall_cycles stays 0.
REQ-033 mem_wait=1 for 3 cycles during a load-use hazard -> FREEZE x3 with the scoreboard held, then exactly 1 STALL.
REQ-034 Counter saturation: force 65536+ stall cycles -> stall_cycles=16'hFFFF and holds.
REQ-035 reset=1 mid-STALL -> next edge state=RUN, counters 0; after release a dependent instruction does not stall.
